// File: rtl/pipe_control_unit_if.sv
// ID-stage inputs and per-stage control outputs of the pipeline control unit.
// The master side is the ID/hazard logic; the slave side is the control unit.
interface pipe_control_unit_if #(
    parameter int unsigned CNT_W = 8
);
    logic [5:0]       op_i;
    logic             id_valid_i;
    logic             stall_i;
    logic             flush_i;
    logic             id_jump_o;
    logic             ex_reg_dst_o;
    logic             ex_alu_src_o;
    logic             ex_mem_read_o;
    logic [1:0]       ex_alu_op_o;
    logic             mem_mem_read_o;
    logic             mem_mem_write_o;
    logic             mem_branch_o;
    logic             mem_branch_ne_o;
    logic             wb_reg_write_o;
    logic             wb_mem_to_reg_o;
    logic [CNT_W-1:0] illegal_cnt_o;

    modport master (
        output op_i, id_valid_i, stall_i, flush_i,
        input  id_jump_o, ex_reg_dst_o, ex_alu_src_o, ex_mem_read_o, ex_alu_op_o,
               mem_mem_read_o, mem_mem_write_o, mem_branch_o, mem_branch_ne_o,
               wb_reg_write_o, wb_mem_to_reg_o, illegal_cnt_o
    );

    modport slave (
        input  op_i, id_valid_i, stall_i, flush_i,
        output id_jump_o, ex_reg_dst_o, ex_alu_src_o, ex_mem_read_o, ex_alu_op_o,
               mem_mem_read_o, mem_mem_write_o, mem_branch_o, mem_branch_ne_o,
               wb_reg_write_o, wb_mem_to_reg_o, illegal_cnt_o
    );
endinterface

// File: rtl/pipe_control_unit.sv
// Opcode decoder and ID/EX -> EX/MEM -> MEM/WB control-word pipeline for the
// five-stage MIPS core, with stall/flush bubbles and a saturating illegal-opcode counter.
module pipe_control_unit #(
    parameter bit          EXT_EN = 1'b1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_control_unit_if.slave bus
);

    // Each stage register keeps only the bits still needed downstream.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    typedef struct packed {
        logic     mem_read;
        logic     mem_write;
        logic     branch;
        logic     branch_ne;
        wb_ctrl_t wb;
    } m_ctrl_t;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
        m_ctrl_t    m;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    ctrl_t            dec;
    logic             illegal;
    logic             accept;
    ctrl_t            id_ex_d, id_ex_q;
    m_ctrl_t          ex_mem_q;
    wb_ctrl_t         mem_wb_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        dec     = '0;
        illegal = 1'b0;
        unique case (bus.op_i)
            OP_RTYPE: begin
                dec.reg_dst      = 1'b1;
                dec.alu_op       = 2'b10;
                dec.m.wb.reg_write = 1'b1;
            end
            OP_LW: begin
                dec.alu_src         = 1'b1;
                dec.m.mem_read      = 1'b1;
                dec.m.wb.mem_to_reg = 1'b1;
                dec.m.wb.reg_write  = 1'b1;
            end
            OP_SW: begin
                dec.alu_src     = 1'b1;
                dec.m.mem_write = 1'b1;
            end
            OP_BEQ: begin
                dec.alu_op   = 2'b01;
                dec.m.branch = 1'b1;
            end
            OP_J: ;  // jump acts in ID only; the word entering ID/EX stays zero
            OP_BNE: begin
                if (EXT_EN) begin
                    dec.alu_op      = 2'b01;
                    dec.m.branch_ne = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_ADDI: begin
                if (EXT_EN) begin
                    dec.alu_src        = 1'b1;
                    dec.m.wb.reg_write = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_ANDI, OP_ORI, OP_SLTI: begin
                if (EXT_EN) begin
                    dec.alu_src        = 1'b1;
                    dec.alu_op         = 2'b11;
                    dec.m.wb.reg_write = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

    // A stalled instruction is not accepted yet, so it neither advances nor counts.
    assign accept  = bus.id_valid_i & ~bus.stall_i & ~bus.flush_i;
    assign id_ex_d = accept ? dec : '0;
    assign cnt_d   = (accept && illegal && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

    // NOTE: sequential state uses non-blocking assignments so all three stages shift on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
            cnt_q    <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= id_ex_q.m;
            mem_wb_q <= ex_mem_q.wb;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.id_jump_o       = bus.id_valid_i & (bus.op_i == OP_J);
    assign bus.ex_reg_dst_o    = id_ex_q.reg_dst;
    assign bus.ex_alu_src_o    = id_ex_q.alu_src;
    assign bus.ex_alu_op_o     = id_ex_q.alu_op;
    assign bus.ex_mem_read_o   = id_ex_q.m.mem_read;
    assign bus.mem_mem_read_o  = ex_mem_q.mem_read;
    assign bus.mem_mem_write_o = ex_mem_q.mem_write;
    assign bus.mem_branch_o    = ex_mem_q.branch;
    assign bus.mem_branch_ne_o = ex_mem_q.branch_ne;
    assign bus.wb_reg_write_o  = mem_wb_q.reg_write;
    assign bus.wb_mem_to_reg_o = mem_wb_q.mem_to_reg;
    assign bus.illegal_cnt_o   = cnt_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Drives an extended (EXT_EN=1, CNT_W=8) and a base (EXT_EN=0, CNT_W=2) control unit
// with the same directed and random stimulus and compares both against a table-driven model.
module tb_pipe_control_unit;

    typedef struct {
        bit       reg_dst;
        bit       alu_src;
        bit [1:0] alu_op;
        bit       mem_read;
        bit       mem_write;
        bit       branch;
        bit       branch_ne;
        bit       mem_to_reg;
        bit       reg_write;
    } word_t;

    logic clk = 1'b0;
    logic rst_n;

    pipe_control_unit_if #(.CNT_W(8)) bus_ext ();
    pipe_control_unit_if #(.CNT_W(2)) bus_base ();

    pipe_control_unit #(.EXT_EN(1'b1), .CNT_W(8)) u_dut_ext (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_ext)
    );

    pipe_control_unit #(.EXT_EN(1'b0), .CNT_W(2)) u_dut_base (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_base)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    word_t       base_tbl[bit [5:0]];
    word_t       ext_tbl[bit [5:0]];
    word_t       m_ex[2], m_mem[2], m_wb[2];
    int unsigned m_cnt[2];
    int unsigned m_cnt_max[2];
    bit          m_ext[2];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic word_t mk(bit rd, bit as, bit [1:0] aop, bit mr, bit mw,
                                 bit br, bit bne, bit m2r, bit rw);
        word_t w;
        w.reg_dst = rd; w.alu_src = as; w.alu_op = aop; w.mem_read = mr;
        w.mem_write = mw; w.branch = br; w.branch_ne = bne;
        w.mem_to_reg = m2r; w.reg_write = rw;
        return w;
    endfunction

    // Control word an accepted opcode should produce; unknown opcodes are illegal zeros.
    function automatic word_t lookup(bit [5:0] op, bit ext, output bit legal);
        legal = 1'b1;
        if (base_tbl.exists(op))             return base_tbl[op];
        if (ext && ext_tbl.exists(op))       return ext_tbl[op];
        legal = 1'b0;
        return mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic model_step(input bit rst, input bit [5:0] op, input bit valid,
                              input bit stall, input bit flush);
        word_t zero = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_ex[k] = zero; m_mem[k] = zero; m_wb[k] = zero; m_cnt[k] = 0;
            end else begin
                bit    legal;
                word_t w = lookup(op, m_ext[k], legal);
                bit    take = valid && !stall && !flush;
                m_wb[k]  = m_mem[k];
                m_mem[k] = m_ex[k];
                m_ex[k]  = take ? w : zero;
                if (take && !legal && m_cnt[k] < m_cnt_max[k]) m_cnt[k] = m_cnt[k] + 1;
            end
        end
    endtask

    task automatic check_dut(input string name, input int k,
                             input logic rd, input logic as, input logic [1:0] aop,
                             input logic exmr, input logic mr, input logic mw,
                             input logic br, input logic bne, input logic rw,
                             input logic m2r, input logic [7:0] cnt);
        check({name, ".ex_reg_dst"},      32'(rd),   32'(m_ex[k].reg_dst));
        check({name, ".ex_alu_src"},      32'(as),   32'(m_ex[k].alu_src));
        check({name, ".ex_alu_op"},       32'(aop),  32'(m_ex[k].alu_op));
        check({name, ".ex_mem_read"},     32'(exmr), 32'(m_ex[k].mem_read));
        check({name, ".mem_mem_read"},    32'(mr),   32'(m_mem[k].mem_read));
        check({name, ".mem_mem_write"},   32'(mw),   32'(m_mem[k].mem_write));
        check({name, ".mem_branch"},      32'(br),   32'(m_mem[k].branch));
        check({name, ".mem_branch_ne"},   32'(bne),  32'(m_mem[k].branch_ne));
        check({name, ".wb_reg_write"},    32'(rw),   32'(m_wb[k].reg_write));
        check({name, ".wb_mem_to_reg"},   32'(m2r),  32'(m_wb[k].mem_to_reg));
        check({name, ".illegal_cnt"},     32'(cnt),  m_cnt[k]);
    endtask

    // Inputs change on the falling edge; registered outputs are sampled 1 ns after the rising edge.
    task automatic cyc(input bit rst, input bit [5:0] op, input bit valid,
                       input bit stall, input bit flush);
        @(negedge clk);
        rst_n = rst;
        bus_ext.op_i  = op; bus_ext.id_valid_i  = valid; bus_ext.stall_i  = stall; bus_ext.flush_i  = flush;
        bus_base.op_i = op; bus_base.id_valid_i = valid; bus_base.stall_i = stall; bus_base.flush_i = flush;
        #1;
        check("ext.id_jump",  32'(bus_ext.id_jump_o),  32'(valid && op == 6'b000010));
        check("base.id_jump", 32'(bus_base.id_jump_o), 32'(valid && op == 6'b000010));
        @(posedge clk);
        model_step(rst, op, valid, stall, flush);
        #1;
        check_dut("ext", 0, bus_ext.ex_reg_dst_o, bus_ext.ex_alu_src_o, bus_ext.ex_alu_op_o,
                  bus_ext.ex_mem_read_o, bus_ext.mem_mem_read_o, bus_ext.mem_mem_write_o,
                  bus_ext.mem_branch_o, bus_ext.mem_branch_ne_o, bus_ext.wb_reg_write_o,
                  bus_ext.wb_mem_to_reg_o, bus_ext.illegal_cnt_o);
        check_dut("base", 1, bus_base.ex_reg_dst_o, bus_base.ex_alu_src_o, bus_base.ex_alu_op_o,
                  bus_base.ex_mem_read_o, bus_base.mem_mem_read_o, bus_base.mem_mem_write_o,
                  bus_base.mem_branch_o, bus_base.mem_branch_ne_o, bus_base.wb_reg_write_o,
                  bus_base.wb_mem_to_reg_o, 8'(bus_base.illegal_cnt_o));
    endtask

    localparam bit [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                         J = 6'b000010, BNE = 6'b000101, ADDI = 6'b001000,
                         ANDI = 6'b001100, ORI = 6'b001101, SLTI = 6'b001010,
                         BAD = 6'b111111;

    initial begin
        bit [5:0] pool[10] = '{R, LW, SW, BEQ, J, BNE, ADDI, ANDI, ORI, SLTI};

        base_tbl[R]    = mk(1, 0, 2'b10, 0, 0, 0, 0, 0, 1);
        base_tbl[LW]   = mk(0, 1, 2'b00, 1, 0, 0, 0, 1, 1);
        base_tbl[SW]   = mk(0, 1, 2'b00, 0, 1, 0, 0, 0, 0);
        base_tbl[BEQ]  = mk(0, 0, 2'b01, 0, 0, 1, 0, 0, 0);
        base_tbl[J]    = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        ext_tbl[BNE]   = mk(0, 0, 2'b01, 0, 0, 0, 1, 0, 0);
        ext_tbl[ADDI]  = mk(0, 1, 2'b00, 0, 0, 0, 0, 0, 1);
        ext_tbl[ANDI]  = mk(0, 1, 2'b11, 0, 0, 0, 0, 0, 1);
        ext_tbl[ORI]   = mk(0, 1, 2'b11, 0, 0, 0, 0, 0, 1);
        ext_tbl[SLTI]  = mk(0, 1, 2'b11, 0, 0, 0, 0, 0, 1);
        m_ext[0] = 1'b1; m_cnt_max[0] = 255;
        m_ext[1] = 1'b0; m_cnt_max[1] = 3;

        rst_n = 1'b0;
        bus_ext.op_i  = '0; bus_ext.id_valid_i  = 1'b0; bus_ext.stall_i  = 1'b0; bus_ext.flush_i  = 1'b0;
        bus_base.op_i = '0; bus_base.id_valid_i = 1'b0; bus_base.stall_i = 1'b0; bus_base.flush_i = 1'b0;

        cyc(0, R, 0, 0, 0);
        cyc(0, LW, 1, 1, 1);

        // Back-to-back base opcodes.
        foreach (pool[i]) if (i < 5) cyc(1, pool[i], 1, 0, 0);
        repeat (3) cyc(1, R, 0, 0, 0);

        // Load-use stall with R held, then flushed sw.
        cyc(1, LW, 1, 0, 0);
        cyc(1, R, 1, 1, 0);
        cyc(1, R, 1, 0, 0);
        cyc(1, SW, 1, 0, 1);
        repeat (3) cyc(1, R, 0, 0, 0);

        // Extended opcodes: legal on ext, illegal on base.
        cyc(1, ORI, 1, 0, 0);
        cyc(1, BNE, 1, 0, 0);
        repeat (3) cyc(1, R, 0, 0, 0);
        check("base.cnt_after_ext_ops", 32'(bus_base.illegal_cnt_o), 32'd2);

        // Counter saturation, then stalled illegal opcodes must not count.
        repeat (5) cyc(1, BAD, 1, 0, 0);
        check("base.cnt_saturated", 32'(bus_base.illegal_cnt_o), 32'd3);
        check("ext.cnt_after_bad",  32'(bus_ext.illegal_cnt_o),  32'd5);
        repeat (3) cyc(1, BAD, 1, 1, 0);
        check("ext.cnt_stalled",    32'(bus_ext.illegal_cnt_o),  32'd5);

        // Full pipeline, reset for one edge, then idle.
        cyc(1, LW, 1, 0, 0);
        cyc(1, R, 1, 0, 0);
        cyc(1, LW, 1, 0, 0);
        cyc(0, R, 1, 0, 0);
        repeat (3) cyc(1, R, 0, 0, 0);

        // Random traffic, including occasional mid-stream resets.
        for (int n = 0; n < 400; n++) begin
            bit [5:0] op = ($urandom_range(0, 9) < 8) ? pool[$urandom_range(0, 9)] : 6'($urandom);
            cyc($urandom_range(0, 49) != 0, op, $urandom_range(0, 9) < 8,
                $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
        end
        repeat (3) cyc(1, R, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
